// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: a single-outstanding valid/ready bus access with
// load extension, store lane/mask generation and fault reporting.
module lsu_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    input  logic            mem_r,
    input  logic            mem_w,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic [1:0]      fault,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wmask,
    input  logic            bus_resp_valid,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state, state_next;
    logic            go;
    logic            illegal, misaligned;
    logic [2:0]      f3_q;
    logic [2:0]      off_q;
    logic            we_q;
    logic [7:0]      base_mask;
    logic [XLEN-1:0] shifted, ext;

    assign go = inst_valid & (mem_r | mem_w);

    always_comb begin
        illegal    = (mem_r & mem_w) | (mem_r & (funct3 == 3'b111)) | (mem_w & funct3[2]);
        misaligned = 1'b0;
        base_mask  = 8'h01;
        case (funct3[1:0])
            2'b01: begin misaligned = addr[0];          base_mask = 8'h03; end
            2'b10: begin misaligned = |addr[1:0];       base_mask = 8'h0F; end
            2'b11: begin misaligned = |addr[2:0];       base_mask = 8'hFF; end
            default: begin misaligned = 1'b0;           base_mask = 8'h01; end
        endcase
    end

    // Load data is taken relative to the latched byte offset and size.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  ext = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (go) state_next = (illegal | misaligned) ? DONE : REQ;
            REQ:  if (bus_req_ready) state_next = WAIT;
            WAIT: if (bus_resp_valid) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus_req_valid = (state == REQ);
    assign done          = (state == DONE);
    assign stall         = ((state == IDLE) & go) | (state == REQ) | (state == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            f3_q      <= '0;
            off_q     <= '0;
            we_q      <= 1'b0;
            rdata     <= '0;
            fault     <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (go) begin
                    f3_q  <= funct3;
                    off_q <= addr[2:0];
                    we_q  <= mem_w;
                    rdata <= '0;
                    fault <= {illegal, misaligned};
                    // Bus fields only move when a request will actually issue.
                    if (!(illegal | misaligned)) begin
                        bus_we    <= mem_w;
                        bus_addr  <= {addr[XLEN-1:3], 3'b000};
                        bus_wdata <= mem_w ? (wdata << {addr[2:0], 3'b000}) : '0;
                        bus_wmask <= mem_w ? (base_mask << addr[2:0]) : 8'h00;
                    end
                end
                WAIT: if (bus_resp_valid && !we_q) rdata <= ext;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized
// accesses checked against a byte-level reference model.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, mem_r, mem_w;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata;
    logic        stall, done;
    logic [63:0] rdata;
    logic [1:0]  fault;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lsu_unit #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .mem_r(mem_r), .mem_w(mem_w),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .rdata(rdata), .fault(fault), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_resp_valid(bus_resp_valid),
        .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [1:0]  fault;
        logic [63:0] baddr;
        logic [63:0] bwdata;
        logic [7:0]  mask;
        logic [63:0] rdata;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Reference: treat memory words as byte arrays and apply the access rules directly.
    function automatic exp_t model(input logic r, input logic w, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] wd,
                                   input logic [63:0] rd);
        exp_t e;
        int n = 1 << f3[1:0];
        int o = int'(a[2:0]);
        e.fault[1] = (r && w) || (r && f3 == 3'd7) || (w && f3[2]);
        e.fault[0] = (o % n) != 0;
        e.baddr  = a & ~64'd7;
        e.mask   = '0;
        e.bwdata = '0;
        e.rdata  = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= o && i < o + n) e.mask[i] = 1'b1;
            if (i >= o) e.bwdata[8*i +: 8] = wd[8*(i-o) +: 8];
        end
        if (!w && e.fault == 2'b00) begin
            for (int k = 0; k < n; k++) e.rdata[8*k +: 8] = rd[8*(o+k) +: 8];
            if (!f3[2] && n < 8 && e.rdata[8*n-1])
                for (int k = n; k < 8; k++) e.rdata[8*k +: 8] = 8'hFF;
        end
        return e;
    endfunction

    task automatic access(input logic r, input logic w, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                          input int rdy_dly, input int rsp_dly);
        exp_t e;
        int   req_cnt = 0, wait_cnt = 0, lat = -1;
        logic accepted = 0, saw_req = 0;
        int   exp_lat;
        e = model(r, w, f3, a, wd, rd);
        exp_lat = (e.fault != 0) ? 1 : rdy_dly + rsp_dly + 3;
        @(negedge clk);
        chk("idle_no_done", done, 0);
        inst_valid = 1; mem_r = r; mem_w = w; funct3 = f3; addr = a; wdata = wd;
        bus_req_ready = 0; bus_resp_valid = 0;
        #1;
        chk("go_stall", stall, 1);
        for (int c = 1; c <= 64 && lat < 0; c++) begin
            @(negedge clk);
            bus_req_ready = 0; bus_resp_valid = 0; bus_rdata = {$urandom, $urandom};
            if (done) begin
                lat = c;
                chk("latency", lat, exp_lat);
                chk("rdata", rdata, e.rdata);
                chk("fault", fault, e.fault);
                chk("done_stall", stall, 0);
            end else begin
                chk("busy_stall", stall, 1);
                if (bus_req_valid) begin
                    saw_req = 1;
                    chk("bus_addr", bus_addr, e.baddr);
                    chk("bus_we", bus_we, w);
                    if (w) begin
                        chk("bus_wmask", bus_wmask, e.mask);
                        chk("bus_wdata", bus_wdata, e.bwdata);
                    end
                    if (req_cnt == rdy_dly) begin bus_req_ready = 1; accepted = 1; end
                    req_cnt++;
                end else if (accepted) begin
                    if (wait_cnt == rsp_dly) begin bus_resp_valid = 1; bus_rdata = rd; end
                    wait_cnt++;
                end
            end
        end
        chk("done_seen", lat > 0, 1);
        chk("req_issued", saw_req, e.fault == 0);
        inst_valid = 0; mem_r = 0; mem_w = 0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        logic        r, w;
        int          kind;
        rst_n = 0; inst_valid = 0; mem_r = 0; mem_w = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_rdata = 0;
        #12;
        chk("rst_state_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_req_valid", bus_req_valid, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wmask", bus_wmask, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1;

        // LB sign-extension at offset 5
        access(1, 0, 3'b000, 64'h8000_0005, 64'h0, 64'h0000_80FF_0000_0000, 0, 0);
        // SH into the top halfword lane
        access(0, 1, 3'b001, 64'h8000_0006, 64'h1234, 64'h0, 0, 0);
        // LD with request and response wait states
        access(1, 0, 3'b011, 64'h8000_0010, 64'h0, 64'hDEAD_BEEF_0123_4567, 3, 2);
        // misaligned LW and illegal load funct3
        access(1, 0, 3'b010, 64'h8000_0002, 64'h0, 64'h0, 0, 0);
        access(1, 0, 3'b111, 64'h8000_0000, 64'h0, 64'h0, 0, 0);
        // back-to-back LWU then SD
        access(1, 0, 3'b110, 64'h8000_0004, 64'h0, 64'hF234_5678_0000_0000, 0, 1);
        access(0, 1, 3'b011, 64'h8000_0008, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 1, 0);

        // reset while waiting for a response
        @(negedge clk);
        inst_valid = 1; mem_r = 1; funct3 = 3'b011; addr = 64'h8000_0100;
        @(negedge clk);
        chk("rstw_req", bus_req_valid, 1);
        bus_req_ready = 1;
        @(negedge clk);
        bus_req_ready = 0; inst_valid = 0; mem_r = 0;
        chk("rstw_wait_stall", stall, 1);
        #2 rst_n = 0;
        #1;
        chk("rstw_stall", stall, 0);
        chk("rstw_req_valid", bus_req_valid, 0);
        chk("rstw_done", done, 0);
        chk("rstw_addr", bus_addr, 0);
        chk("rstw_rdata", rdata, 0);
        chk("rstw_fault", fault, 0);
        @(negedge clk);
        rst_n = 1;
        bus_resp_valid = 1; bus_rdata = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_resp_done", done, 0);
            chk("late_resp_stall", stall, 0);
            chk("late_resp_req", bus_req_valid, 0);
        end
        bus_resp_valid = 0;

        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 15));
            r = (kind < 8) || (kind == 0);
            w = (kind >= 8) || (kind == 0);
            f3 = 3'($urandom_range(0, 7));
            a = {32'h0, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            access(r, w, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        @(negedge clk);
        chk("final_no_done", done, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
